// File: rtl/conv_sched.sv
// conv_sched: shares one convolution engine among NREQ requesters.
//
// A round-robin arbiter picks a requester while IDLE. Its filter is latched
// into eng_filter and its grant is held through LOAD, RUN and DONE. The engine
// is held in reset during IDLE and LOAD. RUN lasts until the engine reports
// completion or TIMEOUT cycles elapse. DONE is a single cycle that pulses
// ack or err at the granted requester's bit.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   req         in   [NREQ]          per-requester job request (level)
//   req_filter  in   [NREQ*KSIZE^2]  per-requester filters, slice i at i*KSIZE^2
//   gnt         out  [NREQ]          one-hot grant, held for the whole job
//   ack         out  [NREQ]          one-cycle completion pulse
//   err         out  [NREQ]          one-cycle timeout pulse
//   cur_id      out  [IW]            granted requester index, 0 when idle
//   busy        out                  high in every state except IDLE
//   eng_reset   out                  synchronous reset to the engine
//   eng_filter  out  [KSIZE^2]       filter latched for the current job
//   eng_done    in                   engine completion level
module conv_sched #(
    parameter int NREQ    = 4,
    parameter int KSIZE   = 3,
    parameter int TIMEOUT = 1024,
    localparam int FW = KSIZE * KSIZE,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*FW-1:0] req_filter,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    err,
    output logic [IW-1:0]      cur_id,
    output logic               busy,
    output logic               eng_reset,
    output logic [FW-1:0]      eng_filter,
    input  logic               eng_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_cur_id;
    logic [IW-1:0]   r_last_id;
    logic [FW-1:0]   r_eng_filter;
    logic [CW-1:0]   r_cnt;
    logic            r_ack_flag;
    logic            r_err_flag;

    logic            w_found;
    logic [IW-1:0]   w_win_id;
    logic [NREQ-1:0] w_win_onehot;
    int              w_idx;
    logic            w_done_ok;
    logic            w_timeout;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(r_last_id) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = IW'(w_idx);
            end
        end
    end

    assign w_win_onehot = NREQ'(1) << w_win_id;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next    = r_state;
        w_done_ok = 1'b0;
        w_timeout = 1'b0;
        eng_reset = 1'b0;
        busy      = 1'b1;
        ack       = '0;
        err       = '0;
        case (r_state)
            S_IDLE: begin
                eng_reset = 1'b1;
                busy      = 1'b0;
                if (w_found) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // eng_done may still reflect the previous job here.
                eng_reset = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                // Completion takes priority over a coincident timeout.
                if (eng_done) begin
                    w_next    = S_DONE;
                    w_done_ok = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_next    = S_DONE;
                    w_timeout = 1'b1;
                end
            end
            S_DONE: begin
                // r_gnt is one-hot of cur_id for the whole job.
                if (r_ack_flag) begin
                    ack = r_gnt;
                end
                if (r_err_flag) begin
                    err = r_gnt;
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= '0;
            r_cur_id     <= '0;
            r_last_id    <= IW'(NREQ - 1);
            r_eng_filter <= '0;
            r_cnt        <= '0;
            r_ack_flag   <= 1'b0;
            r_err_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack_flag <= 1'b0;
                    r_err_flag <= 1'b0;
                    if (w_found) begin
                        r_gnt        <= w_win_onehot;
                        r_cur_id     <= w_win_id;
                        r_last_id    <= w_win_id;
                        r_eng_filter <= req_filter[w_win_id * FW +: FW];
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                end
                S_RUN: begin
                    r_cnt      <= r_cnt + CW'(1);
                    r_ack_flag <= w_done_ok;
                    r_err_flag <= w_timeout;
                end
                S_DONE: begin
                    r_gnt      <= '0;
                    r_cur_id   <= '0;
                    r_ack_flag <= 1'b0;
                    r_err_flag <= 1'b0;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign cur_id     = r_cur_id;
    assign eng_filter = r_eng_filter;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed bench for conv_sched (NREQ=4, KSIZE=3, TIMEOUT=16).
// The stimulus process drives jobs and checks cycle-level behaviour. It pushes
// the expected ack/err pulse of every job into a scoreboard queue. A monitor
// pops that queue whenever the DUT raises ack or err and compares the pulse.
module tb_conv_sched;

    localparam int NREQ    = 4;
    localparam int KSIZE   = 3;
    localparam int TIMEOUT = 16;
    localparam int FW      = KSIZE * KSIZE;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*FW-1:0] req_filter;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [1:0]         cur_id;
    logic               busy;
    logic               eng_reset;
    logic [FW-1:0]      eng_filter;
    logic               eng_done;

    conv_sched #(.NREQ(NREQ), .KSIZE(KSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_filter (req_filter),
        .gnt        (gnt),
        .ack        (ack),
        .err        (err),
        .cur_id     (cur_id),
        .busy       (busy),
        .eng_reset  (eng_reset),
        .eng_filter (eng_filter),
        .eng_done   (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        int          id;
        logic [8:0]  filt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    int n_total = 0;
    int n_pass  = 0;

    logic [8:0] F0 = 9'h1A5;
    logic [8:0] F1 = 9'h05A;
    logic [8:0] F2 = 9'h133;
    logic [8:0] F3 = 9'h0CC;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with req already driven so that exp_id wins.
    task automatic job(input int exp_id, input logic [8:0] exp_filt,
                       input int run_cycles, input bit expect_err, input bit drop_req);
        exp_t e;
        logic [3:0] oh;
        oh = 4'(1 << exp_id);
        e.is_err = expect_err;
        e.id     = exp_id;
        e.filt   = exp_filt;
        sb.push_back(e);
        tick();  // LOAD
        chk("load_gnt", 64'(gnt), 64'(oh));
        chk("load_cur_id", 64'(cur_id), 64'(exp_id));
        chk("load_eng_reset", 64'(eng_reset), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_filter", 64'(eng_filter), 64'(exp_filt));
        if (drop_req) req = '0;
        tick();  // RUN cycle 1
        chk("run_eng_reset", 64'(eng_reset), 64'd0);
        for (int i = 2; i <= run_cycles; i++) begin
            chk("run_no_pulse", 64'({ack, err}), 64'd0);
            tick();
        end
        chk("run_last_no_pulse", 64'({ack, err}), 64'd0);
        chk("run_last_gnt", 64'(gnt), 64'(oh));
        if (!expect_err) eng_done = 1'b1;
        tick();  // DONE
        chk("done_gnt", 64'(gnt), 64'(oh));
        chk("done_eng_reset", 64'(eng_reset), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        eng_done = 1'b0;
        tick();  // IDLE
        chk("idle_gnt", 64'(gnt), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_cur_id", 64'(cur_id), 64'd0);
        chk("idle_eng_reset", 64'(eng_reset), 64'd1);
    endtask

    // Monitor: every ack/err pulse must match the oldest expected job.
    always @(negedge clk) begin
        if ((ack | err) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'({ack, err}), 64'd0);
            end else begin
                m_e = sb.pop_front();
                chk("sb_ack", 64'(ack), m_e.is_err ? 64'd0 : 64'(1 << m_e.id));
                chk("sb_err", 64'(err), m_e.is_err ? 64'(1 << m_e.id) : 64'd0);
                chk("sb_cur_id", 64'(cur_id), 64'(m_e.id));
                chk("sb_gnt", 64'(gnt), 64'(1 << m_e.id));
                chk("sb_filter", 64'(eng_filter), 64'(m_e.filt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        eng_done   = 1'b0;
        req_filter = {F3, F2, F1, F0};
        tick();
        tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack_err", 64'({ack, err}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_id", 64'(cur_id), 64'd0);
        chk("rst_filter", 64'(eng_filter), 64'd0);
        chk("rst_eng_reset", 64'(eng_reset), 64'd1);
        reset = 1'b0;
        tick();

        // Single job; req dropped in LOAD must not abort it.
        req = 4'b0001;
        job(0, F0, 9, 1'b0, 1'b1);

        // Mid-job reset: requester 1 wins (last was 0), reset during RUN.
        req = 4'b0010;
        tick();
        chk("mr_load_gnt", 64'(gnt), 64'b0010);
        tick();
        tick();
        chk("mr_run_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        chk("mr_gnt", 64'(gnt), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_cur_id", 64'(cur_id), 64'd0);
        chk("mr_eng_reset", 64'(eng_reset), 64'd1);
        chk("mr_filter", 64'(eng_filter), 64'd0);
        reset = 1'b0;

        // Fairness after reset: requester 0 first, then rotate.
        req = 4'b1111;
        job(0, F0, 3, 1'b0, 1'b0);
        job(1, F1, 3, 1'b0, 1'b0);
        job(2, F2, 3, 1'b0, 1'b0);
        job(3, F3, 3, 1'b0, 1'b0);
        job(0, F0, 3, 1'b0, 1'b0);
        req = '0;
        tick();

        // Timeout on requester 2, then requester 3 granted next.
        req = 4'b1100;
        job(2, F2, TIMEOUT, 1'b1, 1'b0);
        job(3, F3, 4, 1'b0, 1'b0);
        req = '0;
        tick();

        // Completion coinciding with the timeout cycle wins.
        req = 4'b0001;
        job(0, F0, TIMEOUT, 1'b0, 1'b1);

        // Stale eng_done through IDLE/LOAD, filter changed during the job.
        begin
            exp_t e;
            e.is_err = 1'b0;
            e.id     = 1;
            e.filt   = F1;
            sb.push_back(e);
        end
        eng_done = 1'b1;
        req      = 4'b0010;
        chk("st_idle_no_pulse", 64'({ack, err}), 64'd0);
        tick();  // LOAD
        chk("st_load_gnt", 64'(gnt), 64'b0010);
        chk("st_load_no_pulse", 64'({ack, err}), 64'd0);
        chk("st_load_filter", 64'(eng_filter), 64'(F1));
        req_filter = ~{F3, F2, F1, F0};
        req        = '0;
        tick();  // RUN
        chk("st_run_no_pulse", 64'({ack, err}), 64'd0);
        chk("st_run_eng_reset", 64'(eng_reset), 64'd0);
        chk("st_run_filter", 64'(eng_filter), 64'(F1));
        tick();  // DONE
        chk("st_done_filter", 64'(eng_filter), 64'(F1));
        chk("st_done_busy", 64'(busy), 64'd1);
        eng_done = 1'b0;
        tick();  // IDLE
        chk("st_idle_busy", 64'(busy), 64'd0);
        req_filter = {F3, F2, F1, F0};

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one convolution engine.
REQ-002 The block SHALL have parameter KSIZE, default 3, giving the kernel edge; filter width is KSIZE*KSIZE bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum RUN cycles before a job is aborted.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester job request, level.
REQ-007 req_filter  in  NREQ*KSIZE*KSIZE  per-requester filter; slice i at [i*KSIZE*KSIZE +: KSIZE*KSIZE].
REQ-008 gnt  out  NREQ  one-hot grant, held for the whole job.
REQ-009 ack  out  NREQ  one-cycle pulse on job completion.
REQ-010 err  out  NREQ  one-cycle pulse on job timeout.
REQ-011 cur_id  out  max(1,$clog2(NREQ))  index of the granted requester; 0 when idle.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 eng_reset  out  1  synchronous reset to the engine.
REQ-014 eng_filter  out  KSIZE*KSIZE  registered filter driven to the engine.
REQ-015 eng_done  in  1  engine completion level; stays high until the engine is reset.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-017 IDLE: eng_reset=1 and gnt=0; if any req bit is high, the block SHALL select a winner and enter LOAD on the next edge, else stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_id+1) mod NREQ and the first asserted req wins; last_id updates on entry to LOAD.
REQ-019 On the IDLE->LOAD edge the block SHALL register the winner's req_filter slice into eng_filter, set cur_id, and set gnt to one-hot of the winner.
REQ-020 LOAD SHALL last exactly one cycle with eng_reset=1, then enter RUN.
REQ-021 RUN: eng_reset=0; a cycle counter SHALL clear on entry and increment each RUN cycle.
REQ-022 In RUN, eng_done=1 SHALL cause DONE with ack[cur_id]=1 during the DONE cycle.
REQ-023 In RUN, a counter value of TIMEOUT-1 with eng_done=0 SHALL cause DONE with err[cur_id]=1 and ack=0.
REQ-024 If eng_done=1 and the timeout condition coincide, completion SHALL win: ack, not err.
REQ-025 eng_done SHALL be ignored in IDLE and LOAD, since it may still reflect the previous job.
REQ-026 DONE SHALL last one cycle with gnt still asserted and eng_reset=0, then return to IDLE with gnt cleared.
REQ-027 ack and err SHALL never both be high, and each SHALL be high only in DONE and only at bit cur_id.
REQ-028 Deassertion of req during LOAD, RUN or DONE SHALL NOT abort the job; the job completes normally.
REQ-029 eng_filter SHALL remain stable from LOAD through DONE regardless of req_filter changes.
REQ-030 A requester still holding req in IDLE after its ack SHALL be re-arbitrated normally.
REQ-031 Minimum latency: req rising in IDLE at cycle t gives gnt at t+1, RUN at t+2, and earliest ack at t+3 if eng_done is already high at t+2.

Reset
REQ-032 On reset the block SHALL enter IDLE and set gnt=0, ack=0, err=0, busy=0, cur_id=0, eng_filter=0, eng_reset=1, counter=0, and last_id=NREQ-1, so requester 0 has first priority.
REQ-033 Reset asserted mid-job SHALL abort the job with no ack or err pulse, and take effect on the next edge.

Verification
REQ-034 Single job: req=4'b0001, eng_done rises 9 cycles into RUN -> gnt=4'b0001 one cycle after req, eng_reset high 1 cycle in LOAD, one ack[0] pulse, busy low afterwards.
REQ-035 Fairness: req=4'b1111 held, eng_done 3 cycles into each RUN -> grant order 0,1,2,3,0, exactly one ack per job.
REQ-036 Timeout: TIMEOUT=16, eng_done held 0 -> err[cur_id] pulse after exactly 16 RUN cycles, no ack, next requester granted.
REQ-037 Coincidence: eng_done rises on the 16th RUN cycle with TIMEOUT=16 -> ack only, err stays 0.
REQ-038 Stale done and filter: eng_done held 1 through IDLE/LOAD, req_filter changed during RUN -> no early ack, eng_filter unchanged until DONE.
REQ-039 Mid-job reset: reset pulsed in RUN -> next cycle IDLE, gnt=0, no ack/err, then requester 0 has priority.
